// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between an upstream word source (master)
// and the serializer (slave).
interface seq_serializer_if #(
  parameter int WIDTH = 14
);
  logic [WIDTH-1:0] data_in;
  logic             data_valid;
  logic             data_ready;
  logic             seq_out;
  logic             seq_valid;
  logic             busy;
  logic [4:0]       bit_cnt;

  modport master (
    output data_in, data_valid,
    input  data_ready, seq_out, seq_valid, busy, bit_cnt
  );

  modport slave (
    input  data_in, data_valid,
    output data_ready, seq_out, seq_valid, busy, bit_cnt
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready,
// one bit per clock out, MSB first, with gapless back-to-back streaming.
module seq_serializer #(
  parameter int   WIDTH      = 14,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_serializer_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [4:0] LAST = 5'(WIDTH - 1);

  state_t           state_q;
  // Only the not-yet-transmitted bits are kept; the MSB goes straight to seq_out_q.
  logic [WIDTH-2:0] rest_q;
  logic             seq_out_q;
  logic             seq_valid_q;
  logic             busy_q;
  logic [4:0]       bit_cnt_q;

  logic ready_d;
  logic xfer_d;

  assign ready_d = rst_n && ((state_q == IDLE) || (bit_cnt_q == LAST));
  assign xfer_d  = ready_d && bus.data_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rest_q      <= '0;
      seq_out_q   <= IDLE_LEVEL;
      seq_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      bit_cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer_d) begin
            state_q     <= SHIFT;
            rest_q      <= bus.data_in[WIDTH-2:0];
            seq_out_q   <= bus.data_in[WIDTH-1];
            seq_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            bit_cnt_q   <= 5'd0;
          end
        end
        SHIFT: begin
          if (bit_cnt_q != LAST) begin
            rest_q    <= rest_q << 1;
            seq_out_q <= rest_q[WIDTH-2];
            bit_cnt_q <= bit_cnt_q + 5'd1;
          end else if (xfer_d) begin
            // Last bit overlaps the next load so the stream has no bubble.
            rest_q      <= bus.data_in[WIDTH-2:0];
            seq_out_q   <= bus.data_in[WIDTH-1];
            seq_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            bit_cnt_q   <= 5'd0;
          end else begin
            state_q     <= IDLE;
            seq_out_q   <= IDLE_LEVEL;
            seq_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            bit_cnt_q   <= 5'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_ready = ready_d;
  assign bus.seq_out    = seq_out_q;
  assign bus.seq_valid  = seq_valid_q;
  assign bus.busy       = busy_q;
  assign bus.bit_cnt    = bit_cnt_q;

endmodule
